// File: rtl/ldb_pkg.sv
// ldb_pkg: shared definitions for the load-buffer shell.
//   - ldb_state_e   : one-hot FSM state encoding (also driven on o_state)
//   - brst_to_beats : burst code -> beats per SMC (00=1, 01=2, 10=4, 11=8)
//   - SMC_COUNT_DEF / INTLV_STEP_DEF : default bank count and interleave step
package ldb_pkg;

  localparam int SMC_COUNT_DEF  = 6;
  localparam int INTLV_STEP_DEF = 16;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_INIT    = 5'b00010,
    ST_SMC_DET = 5'b00100,
    ST_READ    = 5'b01000,
    ST_DONE    = 5'b10000
  } ldb_state_e;

  function automatic logic [3:0] brst_to_beats(input logic [1:0] brst);
    case (brst)
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/ldb_smc_sel.sv
// ldb_smc_sel: combinational lowest-set-bit priority encoder over the
// remaining SMC mask.
// Ports:
//   mask   in  N   remaining SMC enable mask
//   idx    out KW  index of the lowest set bit (0 when mask is empty)
//   onehot out N   one-hot of idx (all zero when mask is empty)
//   any    out 1   mask has at least one bit set
module ldb_smc_sel
  import ldb_pkg::*;
#(
  parameter int N  = SMC_COUNT_DEF,
  parameter int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [KW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          any
);

  // Scan from the top down so the lowest set bit is the last (winning) write.
  always_comb begin
    idx    = '0;
    onehot = '0;
    any    = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx       = KW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldb_shell.sv
// ldb_shell: load-buffer shell. Takes one load micro-instruction at a time,
// reads `beats` interleaved 128-bit beats from each enabled SMC bank (lowest
// bank first) and writes them to consecutive entries of the selected UR.
//
// Optional feature macro: LDB_BYTE_STRB_EN
//   defined   : 32-bit words whose byte_strb bit is 0 are zeroed in the UR
//               write data, and o_ur_wr_strb = byte_strb.
//   undefined : byte_strb is ignored, data passes through, o_ur_wr_strb = 4'hF.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_micro_inst_u_*              instruction (valid/ready, smc/byte strobes,
//                                 burst code, base address, UR id, UR address)
//   o_smc_rd_req_valid/_sel/_addr read request to the SMC banks
//   i_smc_rd_req_ready            request accept
//   i_smc_rd_rsp_valid/_data      in-order read responses
//   o_ur_wr_*                     registered UR write port
//   o_micro_inst_d_valid          mirrors o_ur_wr_en
//   o_micro_inst_d_done           one-cycle completion pulse (DONE state)
//   o_state                       one-hot FSM state
//
// Handshakes: an instruction transfers on a cycle with valid & ready (ready is
// high only in IDLE); a read request transfers on valid & ready and valid is
// held with stable sel/addr until it does; responses have no backpressure and
// are only honoured while at least one request is outstanding.
module ldb_shell
  import ldb_pkg::*;
#(
  parameter int UR_ADDR_WIDTH   = 11,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int SMC_COUNT       = SMC_COUNT_DEF,
  parameter int INTLV_STEP      = INTLV_STEP_DEF,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_micro_inst_u_valid,
  output logic                     o_micro_inst_u_ready,
  input  logic [SMC_COUNT-1:0]     i_micro_inst_u_smc_strb,
  input  logic [3:0]               i_micro_inst_u_byte_strb,
  input  logic [1:0]               i_micro_inst_u_brst,
  input  logic [ADDR_WIDTH-1:0]    i_micro_inst_u_gr_base_addr,
  input  logic [3:0]               i_micro_inst_u_ur_id,
  input  logic [UR_ADDR_WIDTH-1:0] i_micro_inst_u_ur_addr,
  output logic                     o_smc_rd_req_valid,
  input  logic                     i_smc_rd_req_ready,
  output logic [SMC_COUNT-1:0]     o_smc_rd_sel,
  output logic [ADDR_WIDTH-1:0]    o_smc_rd_addr,
  input  logic                     i_smc_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    i_smc_rd_rsp_data,
  output logic                     o_ur_wr_en,
  output logic [3:0]               o_ur_wr_id,
  output logic [UR_ADDR_WIDTH-1:0] o_ur_wr_addr,
  output logic [DATA_WIDTH-1:0]    o_ur_wr_data,
  output logic [3:0]               o_ur_wr_strb,
  output logic                     o_micro_inst_d_valid,
  output logic                     o_micro_inst_d_done,
  output logic [4:0]               o_state
);

  localparam int KW     = (SMC_COUNT > 1) ? $clog2(SMC_COUNT) : 1;
  localparam int WORD_W = DATA_WIDTH / 4;

  ldb_state_e               state;
  logic [SMC_COUNT-1:0]     mask;
  logic [SMC_COUNT-1:0]     sel_q;
  logic [KW-1:0]            k;
  logic [1:0]               brst_q;
  logic [3:0]               ur_id_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [UR_ADDR_WIDTH-1:0] ur_ptr;
  logic [3:0]               beats;
  logic [3:0]               issue_cnt;
  logic [3:0]               rsp_cnt;
  logic [3:0]               outstanding;

  logic [KW-1:0]            sel_idx;
  logic [SMC_COUNT-1:0]     sel_onehot;
  logic                     sel_any;

  logic                     req_valid;
  logic                     req_fire;
  logic                     rsp_take;
  logic [3:0]               rsp_cnt_nxt;
  logic [SMC_COUNT-1:0]     mask_left;
  logic [ADDR_WIDTH-1:0]    beat_slot;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    wr_data_nxt;
  logic [3:0]               wr_strb_nxt;

  ldb_smc_sel #(
    .N  (SMC_COUNT),
    .KW (KW)
  ) u_smc_sel (
    .mask   (mask),
    .idx    (sel_idx),
    .onehot (sel_onehot),
    .any    (sel_any)
  );

  // Requests stop once every beat for this bank is issued or the in-flight
  // window is full; they resume as responses drain the window.
  assign req_valid   = (state == ST_READ) && (issue_cnt < beats) &&
                       (outstanding < 4'(MAX_OUTSTANDING));
  assign req_fire    = req_valid && i_smc_rd_req_ready;
  // Responses with nothing outstanding (idle, or stale after a reset) are dropped.
  assign rsp_take    = i_smc_rd_rsp_valid && (outstanding != 4'd0);
  assign rsp_cnt_nxt = rsp_cnt + {3'b000, rsp_take};
  assign mask_left   = mask & ~sel_q;

  // Beat b of bank k sits at slot b*SMC_COUNT + k of the interleaved space.
  assign beat_slot = ADDR_WIDTH'(issue_cnt) * ADDR_WIDTH'(SMC_COUNT) + ADDR_WIDTH'(k);
  assign req_addr  = base_q + beat_slot * ADDR_WIDTH'(INTLV_STEP);

  assign o_smc_rd_req_valid   = req_valid;
  assign o_smc_rd_sel         = req_valid ? sel_q : '0;
  assign o_smc_rd_addr        = req_valid ? req_addr : '0;
  assign o_micro_inst_u_ready = (state == ST_IDLE);
  assign o_micro_inst_d_valid = o_ur_wr_en;
  assign o_micro_inst_d_done  = (state == ST_DONE);
  assign o_state              = state;

`ifdef LDB_BYTE_STRB_EN
  logic [3:0] byte_strb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_strb_q <= '0;
    end else if (state == ST_IDLE && i_micro_inst_u_valid) begin
      byte_strb_q <= i_micro_inst_u_byte_strb;
    end
  end

  always_comb begin
    wr_data_nxt = i_smc_rd_rsp_data;
    for (int w = 0; w < 4; w++) begin
      if (!byte_strb_q[w]) begin
        wr_data_nxt[w*WORD_W +: WORD_W] = '0;
      end
    end
  end

  assign wr_strb_nxt = byte_strb_q;
`else
  logic byte_strb_unused;

  assign byte_strb_unused = ^i_micro_inst_u_byte_strb;
  assign wr_data_nxt      = i_smc_rd_rsp_data;
  assign wr_strb_nxt      = 4'hF;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mask         <= '0;
      sel_q        <= '0;
      k            <= '0;
      brst_q       <= '0;
      ur_id_q      <= '0;
      base_q       <= '0;
      ur_ptr       <= '0;
      beats        <= '0;
      issue_cnt    <= '0;
      rsp_cnt      <= '0;
      outstanding  <= '0;
      o_ur_wr_en   <= 1'b0;
      o_ur_wr_id   <= '0;
      o_ur_wr_addr <= '0;
      o_ur_wr_data <= '0;
      o_ur_wr_strb <= '0;
    end else begin
      // Accept and response in the same cycle cancel out.
      outstanding <= outstanding + {3'b000, req_fire} - {3'b000, rsp_take};
      if (req_fire) begin
        issue_cnt <= issue_cnt + 4'd1;
      end
      if (rsp_take) begin
        rsp_cnt <= rsp_cnt_nxt;
      end

      o_ur_wr_en <= rsp_take;
      if (rsp_take) begin
        o_ur_wr_id   <= ur_id_q;
        o_ur_wr_addr <= ur_ptr;
        o_ur_wr_data <= wr_data_nxt;
        o_ur_wr_strb <= wr_strb_nxt;
        ur_ptr       <= ur_ptr + 1'b1;  // wraps at 2^UR_ADDR_WIDTH
      end

      case (state)
        ST_IDLE: begin
          // Mask and UR pointer load straight from the instruction; INIT then
          // only has to decode the burst and branch on an empty mask.
          if (i_micro_inst_u_valid) begin
            mask    <= i_micro_inst_u_smc_strb;
            brst_q  <= i_micro_inst_u_brst;
            base_q  <= i_micro_inst_u_gr_base_addr;
            ur_id_q <= i_micro_inst_u_ur_id;
            ur_ptr  <= i_micro_inst_u_ur_addr;
            state   <= ST_INIT;
          end
        end
        ST_INIT: begin
          beats <= brst_to_beats(brst_q);
          state <= (mask == '0) ? ST_DONE : ST_SMC_DET;
        end
        ST_SMC_DET: begin
          k         <= sel_idx;
          sel_q     <= sel_onehot;
          issue_cnt <= '0;
          rsp_cnt   <= '0;
          state     <= sel_any ? ST_READ : ST_DONE;
        end
        ST_READ: begin
          // The last UR write of the bank is registered on this same edge.
          if (rsp_take && rsp_cnt_nxt == beats) begin
            mask  <= mask_left;
            state <= (mask_left != '0) ? ST_SMC_DET : ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
